// File: rtl/channel_head.sv
// Byte FIFO for one RS232 channel direction. It has a registered read port,
// sticky overflow/underflow flags and a priority level derived from occupancy.
module channel_head #(
    parameter int DATA_W          = 8,
    parameter int PRIORITY_LEVELS = 8,
    parameter int DEPTH           = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               channel_enable,
    input  logic                               clear_errors,
    input  logic [DATA_W-1:0]                  channel_data_in,
    input  logic                               commit_channel_data_in,
    output logic [DATA_W-1:0]                  channel_data_out,
    input  logic                               commit_channel_data_read,
    output logic [$clog2(PRIORITY_LEVELS)-1:0] channel_priority,
    output logic                               write_error,
    output logic                               read_error
);

    localparam int PRIO_W = $clog2(PRIORITY_LEVELS);
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + PRIO_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              do_read;
    logic              do_write;
    logic              read_fail;
    logic              write_fail;
    logic [PW-1:0]     prio_num;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A read frees a slot in the same cycle, so a write to a full FIFO still lands.
    assign do_read    = channel_enable && commit_channel_data_read && !empty;
    assign do_write   = channel_enable && commit_channel_data_in && (!full || do_read);
    assign read_fail  = channel_enable && commit_channel_data_read && empty;
    assign write_fail = channel_enable && commit_channel_data_in && !do_write;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= channel_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            channel_data_out <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr           <= rd_ptr + 1'b1;
                channel_data_out <= mem[rd_ptr];
            end
            if (do_write && !do_read) begin
                count <= count + 1'b1;
            end else if (do_read && !do_write) begin
                count <= count - 1'b1;
            end
        end
    end

    // A set event in the same cycle as clear_errors takes precedence over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_error <= 1'b0;
            read_error  <= 1'b0;
        end else if (channel_enable) begin
            if (write_fail) begin
                write_error <= 1'b1;
            end else if (clear_errors) begin
                write_error <= 1'b0;
            end
            if (read_fail) begin
                read_error <= 1'b1;
            end else if (clear_errors) begin
                read_error <= 1'b0;
            end
        end
    end

    // Ceiling of count*(levels-1)/DEPTH, which is non-zero whenever any word is held.
    assign prio_num         = PW'(count) * PW'(PRIORITY_LEVELS - 1) + PW'(DEPTH - 1);
    assign channel_priority = PRIO_W'(prio_num >> AW);

endmodule

// File: tb/tb_channel_head.sv
// Scoreboard bench for channel_head. Accepted writes queue the expected bytes,
// and accepted reads pop them and compare them one cycle later.
module tb_channel_head;

    localparam int DW    = 8;
    localparam int PL    = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          channel_enable;
    logic          clear_errors;
    logic [DW-1:0] channel_data_in;
    logic          commit_channel_data_in;
    logic [DW-1:0] channel_data_out;
    logic          commit_channel_data_read;
    logic [2:0]    channel_priority;
    logic          write_error;
    logic          read_error;

    channel_head #(.DATA_W(DW), .PRIORITY_LEVELS(PL), .DEPTH(DEPTH)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .channel_enable           (channel_enable),
        .clear_errors             (clear_errors),
        .channel_data_in          (channel_data_in),
        .commit_channel_data_in   (commit_channel_data_in),
        .channel_data_out         (channel_data_out),
        .commit_channel_data_read (commit_channel_data_read),
        .channel_priority         (channel_priority),
        .write_error              (write_error),
        .read_error               (read_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    logic [DW-1:0] sb_q [$];
    int     exp_count;
    int     exp_dout;
    int     exp_werr;
    int     exp_rerr;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int prioOf(input int c);
        int p;
        p = c * (PL - 1);
        return (p / DEPTH) + (((p % DEPTH) != 0) ? 1 : 0);
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".dout"}, int'(channel_data_out), exp_dout);
        checkOutput({tag, ".prio"}, int'(channel_priority), prioOf(exp_count));
        checkOutput({tag, ".werr"}, int'(write_error), exp_werr);
        checkOutput({tag, ".rerr"}, int'(read_error), exp_rerr);
    endtask

    task automatic modelReset();
        sb_q.delete();
        exp_count = 0;
        exp_dout  = 0;
        exp_werr  = 0;
        exp_rerr  = 0;
    endtask

    task automatic applyStimulus(input string tag, input bit en, input bit wr,
                                 input logic [DW-1:0] din, input bit rd, input bit clr);
        bit rd_ok, wr_ok, wfail, rfail;
        @(negedge clk);
        channel_enable           = en;
        commit_channel_data_in   = wr;
        channel_data_in          = din;
        commit_channel_data_read = rd;
        clear_errors             = clr;
        rd_ok = en && rd && (exp_count > 0);
        wr_ok = en && wr && ((exp_count < DEPTH) || rd_ok);
        wfail = en && wr && !wr_ok;
        rfail = en && rd && (exp_count == 0);
        if (rd_ok) exp_dout = int'(sb_q.pop_front());
        if (wr_ok) sb_q.push_back(din);
        if (wr_ok && !rd_ok) exp_count++;
        if (rd_ok && !wr_ok) exp_count--;
        if (en) begin
            if (wfail) exp_werr = 1; else if (clr) exp_werr = 0;
            if (rfail) exp_rerr = 1; else if (clr) exp_rerr = 0;
        end
        @(posedge clk);
        #1;
        checkAll(tag);
        commit_channel_data_in   = 1'b0;
        commit_channel_data_read = 1'b0;
        clear_errors             = 1'b0;
    endtask

    initial begin
        rst_n                    = 1'b0;
        channel_enable           = 1'b1;
        clear_errors             = 1'b0;
        channel_data_in          = '0;
        commit_channel_data_in   = 1'b0;
        commit_channel_data_read = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic two-word round trip
        applyStimulus("wrA5", 1, 1, 8'hA5, 0, 0);
        applyStimulus("wr3C", 1, 1, 8'h3C, 0, 0);
        applyStimulus("rd1", 1, 0, 8'h00, 1, 0);
        applyStimulus("rd2", 1, 0, 8'h00, 1, 0);
        applyStimulus("idle", 1, 0, 8'h00, 0, 0);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1, 1, 8'(i), 0, 0);
        checkOutput("full.prio", int'(channel_priority), PL - 1);
        applyStimulus("ovf", 1, 1, 8'hFF, 0, 0);
        checkOutput("ovf.werr", int'(write_error), 1);
        for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1, 0, 8'h00, 1, 0);
        checkOutput("drain.last", int'(channel_data_out), 8'h0F);
        applyStimulus("clr", 1, 0, 8'h00, 0, 1);

        // Underflow and clear precedence
        applyStimulus("udf", 1, 0, 8'h00, 1, 0);
        checkOutput("udf.rerr", int'(read_error), 1);
        applyStimulus("clr2", 1, 0, 8'h00, 0, 1);
        applyStimulus("udfclr", 1, 0, 8'h00, 1, 1);
        checkOutput("udfclr.rerr", int'(read_error), 1);
        applyStimulus("udfwr", 1, 1, 8'h5A, 1, 0);
        applyStimulus("rd5A", 1, 0, 8'h00, 1, 1);

        // Simultaneous read and write while full
        for (int i = 0; i < DEPTH; i++) applyStimulus("fill2", 1, 1, 8'(8'h10 + i), 0, 0);
        applyStimulus("rw77", 1, 1, 8'h77, 1, 0);
        checkOutput("rw77.dout", int'(channel_data_out), 8'h10);
        for (int i = 0; i < DEPTH; i++) applyStimulus("drain2", 1, 0, 8'h00, 1, 0);
        checkOutput("drain2.last", int'(channel_data_out), 8'h77);

        // Disabled channel ignores strobes
        applyStimulus("udf2", 1, 0, 8'h00, 1, 0);
        applyStimulus("wr11", 1, 1, 8'h11, 0, 0);
        applyStimulus("wr22", 1, 1, 8'h22, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("dis", 0, 1, 8'hEE, 1, 1);
        applyStimulus("en.rd", 1, 0, 8'h00, 1, 0);
        applyStimulus("en.rd2", 1, 0, 8'h00, 1, 1);

        // Pointer wrap with steady occupancy
        for (int i = 0; i < 3; i++) applyStimulus("pre", 1, 1, 8'(8'h80 + i), 0, 0);
        for (int i = 0; i < 40; i++) applyStimulus("wrap", 1, 1, 8'($urandom_range(0, 255)), 1, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus("pairw", 1, 1, 8'(8'hC0 + i), 0, 0);
            applyStimulus("pairr", 1, 0, 8'h00, 1, 0);
        end
        for (int i = 0; i < 3; i++) applyStimulus("post", 1, 0, 8'h00, 1, 0);

        // Asynchronous reset mid-stream
        applyStimulus("udf3", 1, 0, 8'h00, 1, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus("fill3", 1, 1, 8'(8'h40 + i), 0, 0);
        applyStimulus("ovf3", 1, 1, 8'hAB, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postrst.wr", 1, 1, 8'h99, 0, 0);
        applyStimulus("postrst.rd", 1, 0, 8'h00, 1, 0);
        checkOutput("postrst.q", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
